// File: rtl/syndrome_frame_ctrl.sv
// rtl/syndrome_frame_ctrl.sv - RS(544,522) codeword sequencer for the syndrome datapath
//
// Purpose: counts 17 beats per codeword and drives the valid/start/last
// strobes of the syndrome datapath. It captures the J syndromes into a
// one-deep result buffer, flags error-free frames, and stalls the upstream
// beat stream when that buffer cannot take another frame.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   in_valid_i/in_ready_o              upstream beat handshake
//   in_sof_i                           first beat of codeword (qualifies in_valid_i)
//   in_data_i                          M symbols of 10 bits, [M-1] highest order
//   syn_valid_o/start_o/last_o/data_o  datapath drive (combinational)
//   syn_s_valid_i, syn_s_i             datapath syndrome result
//   out_valid_o/out_ready_i            result handshake to the key-equation solver
//   out_s_o, out_zero_o, out_tag_o     held syndromes, all-zero flag, frame tag
//   err_sof_o, err_orphan_o            sticky framing / orphan-result errors
module syndrome_frame_ctrl #(
    parameter  int J     = 22,
    parameter  int M     = 32,
    parameter  int N     = 544,
    parameter  int TAG_W = 8,
    localparam int BEATS = N / M,
    localparam int CNT_W = $clog2(BEATS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_sof_i,
    input  logic [M*10-1:0]    in_data_i,
    output logic               syn_valid_o,
    output logic               syn_start_o,
    output logic               syn_last_o,
    output logic [M*10-1:0]    syn_data_o,
    input  logic               syn_s_valid_i,
    input  logic [J*10-1:0]    syn_s_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [J*10-1:0]    out_s_o,
    output logic               out_zero_o,
    output logic [TAG_W-1:0]   out_tag_o,
    output logic               err_sof_o,
    output logic               err_orphan_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               inflight_q, inflight_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               out_valid_q, out_valid_d;
    logic [J*10-1:0]    out_s_q, out_s_d;
    logic               out_zero_q, out_zero_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               err_sof_q, err_sof_d;
    logic               err_orphan_q, err_orphan_d;

    logic in_run, last_pos, stall, acc, drop, restart, capture, orphan;

    always_comb begin
        in_run   = (state_q == RUN);
        last_pos = (beat_cnt_q == CNT_W'(BEATS - 1));
        // Only the closing beat can be held back: it is the beat that would
        // produce a result while the buffer or the datapath is still occupied.
        stall      = last_pos & (inflight_q | (out_valid_q & ~out_ready_i));
        in_ready_o = ~rst_i & ~stall;
        acc        = in_valid_i & in_ready_o;
        drop       = acc & ~in_run & ~in_sof_i;
        restart    = acc & in_run & in_sof_i;

        syn_valid_o = acc & ~drop;
        syn_data_o  = in_data_i;
        // A mid-frame sof restarts the datapath accumulators on this beat.
        syn_start_o = syn_valid_o & ((beat_cnt_q == '0) | in_sof_i);
        syn_last_o  = syn_valid_o & in_run & last_pos & ~in_sof_i;

        capture = syn_s_valid_i;
        // A zero-latency datapath reports on the last beat itself, before
        // inflight has been set, so that case is not an orphan.
        orphan  = capture & ((~inflight_q & ~syn_last_o) | (out_valid_q & ~out_ready_i));

        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (acc) begin
            if (in_sof_i) begin
                beat_cnt_d = CNT_W'(1);
                state_d    = RUN;
            end else if (in_run) begin
                if (last_pos) begin
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
        end

        // Clear wins over set when capture coincides with the last beat.
        inflight_d = capture ? 1'b0 : (syn_last_o ? 1'b1 : inflight_q);

        out_valid_d = capture | (out_valid_q & ~out_ready_i);
        out_s_d     = out_s_q;
        out_zero_d  = out_zero_q;
        out_tag_d   = out_tag_q;
        tag_d       = tag_q;
        if (capture) begin
            out_s_d    = syn_s_i;
            out_zero_d = (syn_s_i == '0);
            out_tag_d  = tag_q;
            tag_d      = tag_q + TAG_W'(1);
        end

        err_sof_d    = err_sof_q | drop | restart;
        err_orphan_d = err_orphan_q | orphan;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            out_s_q      <= '0;
            out_zero_q   <= 1'b0;
            out_tag_q    <= '0;
            err_sof_q    <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            inflight_q   <= inflight_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            out_s_q      <= out_s_d;
            out_zero_q   <= out_zero_d;
            out_tag_q    <= out_tag_d;
            err_sof_q    <= err_sof_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_s_o      = out_s_q;
    assign out_zero_o   = out_zero_q;
    assign out_tag_o    = out_tag_q;
    assign err_sof_o    = err_sof_q;
    assign err_orphan_o = err_orphan_q;

endmodule

// File: tb/tb_syndrome_frame_ctrl.sv
// tb/tb_syndrome_frame_ctrl.sv - self-checking bench for syndrome_frame_ctrl
module tb_syndrome_frame_ctrl;

    localparam int J     = 22;
    localparam int M     = 32;
    localparam int DW    = M * 10;
    localparam int SW    = J * 10;
    localparam int BEATS = 17;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic            in_sof_i;
    logic [DW-1:0]   in_data_i;
    logic            syn_valid_o, syn_start_o, syn_last_o;
    logic [DW-1:0]   syn_data_o;
    logic            syn_s_valid_i;
    logic [SW-1:0]   syn_s_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [SW-1:0]   out_s_o;
    logic            out_zero_o;
    logic [7:0]      out_tag_o;
    logic            err_sof_o, err_orphan_o;

    // Datapath stand-in: zero latency, reports the bench-chosen syndromes
    // on the last beat; dp_force injects an unsolicited result.
    logic            dp_force;
    logic [SW-1:0]   cur_syn;
    assign syn_s_valid_i = syn_last_o | dp_force;
    assign syn_s_i       = cur_syn;

    always #5 clk_i = ~clk_i;

    syndrome_frame_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_sof_i(in_sof_i), .in_data_i(in_data_i),
        .syn_valid_o(syn_valid_o), .syn_start_o(syn_start_o), .syn_last_o(syn_last_o), .syn_data_o(syn_data_o),
        .syn_s_valid_i(syn_s_valid_i), .syn_s_i(syn_s_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_s_o(out_s_o),
        .out_zero_o(out_zero_o), .out_tag_o(out_tag_o),
        .err_sof_o(err_sof_o), .err_orphan_o(err_orphan_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current codeword (0 = no frame
    // open), the held result, the next tag and the sticky error flags.
    int            pos;
    logic          ov_m, oz_m, es_m, eo_m, last_acc;
    logic [SW-1:0] os_m;
    logic [7:0]    ot_m, tag_m;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; ov_m = 0; oz_m = 0; os_m = '0; ot_m = 0; tag_m = 0; es_m = 0; eo_m = 0;
    endtask

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [SW-1:0] rnd_syn();
        logic [DW-1:0] v;
        v = rnd_beat();
        return v[SW-1:0];
    endfunction

    // One clock cycle: drive inputs just after the edge, check combinational
    // outputs mid-cycle, advance the model, check registered outputs after the edge.
    task automatic tick(input logic rst, input logic valid, input logic sof, input logic [DW-1:0] data,
                        input logic oready, input logic force_sv);
        logic e_rdy, e_acc, e_drop, e_sv, e_start, e_last, cap;
        rst_i = rst; in_valid_i = valid; in_sof_i = sof; in_data_i = data;
        out_ready_i = oready; dp_force = force_sv;
        if (rst) model_reset();
        #3;
        e_rdy   = !rst && !(pos == BEATS - 1 && ov_m && !oready);
        e_acc   = valid && e_rdy;
        e_drop  = e_acc && pos == 0 && !sof;
        e_sv    = e_acc && !e_drop;
        e_start = e_sv && sof;
        e_last  = e_sv && !sof && pos == BEATS - 1;
        chk("in_ready", DW'(in_ready_o), DW'(e_rdy));
        chk("syn_valid", DW'(syn_valid_o), DW'(e_sv));
        chk("syn_start", DW'(syn_start_o), DW'(e_start));
        chk("syn_last", DW'(syn_last_o), DW'(e_last));
        chk("syn_data", syn_data_o, data);
        last_acc = e_acc;
        if (!rst) begin
            cap = e_last || force_sv;
            if (cap && (!e_last || (ov_m && !oready))) eo_m = 1;
            if (cap) begin
                os_m = cur_syn; oz_m = (cur_syn == '0); ot_m = tag_m; tag_m = tag_m + 8'd1; ov_m = 1;
            end else if (ov_m && oready) begin
                ov_m = 0;
            end
            if (e_acc && ((pos == 0 && !sof) || (pos != 0 && sof))) es_m = 1;
            if (e_acc) begin
                if (sof) pos = 1;
                else if (pos == BEATS - 1) pos = 0;
                else if (pos != 0) pos = pos + 1;
            end
        end
        @(posedge clk_i); #1;
        chk("out_valid", DW'(out_valid_o), DW'(ov_m));
        chk("out_s", DW'(out_s_o), DW'(os_m));
        chk("out_zero", DW'(out_zero_o), DW'(oz_m));
        chk("out_tag", DW'(out_tag_o), DW'(ot_m));
        chk("err_sof", DW'(err_sof_o), DW'(es_m));
        chk("err_orphan", DW'(err_orphan_o), DW'(eo_m));
    endtask

    // Repeat a beat until accepted (random gaps / ready), bounded.
    task automatic send_beat(input logic sof, input logic [DW-1:0] d, input int ready_pct, input int gap_pct);
        int n = 0;
        do begin
            tick(0, $urandom_range(99) >= gap_pct, sof, d,
                 $urandom_range(99) < ready_pct, 0);
            n++;
        end while (!last_acc && n < 40);
        chk("beat_accepted", DW'(last_acc), DW'(1));
    endtask

    task automatic send_frame(input logic [SW-1:0] syn, input int ready_pct, input int gap_pct);
        cur_syn = syn;
        for (int b = 0; b < BEATS; b++) send_beat(b == 0, rnd_beat(), ready_pct, gap_pct);
    endtask

    initial begin
        logic [SW-1:0] ones;
        for (int i = 0; i < J; i++) ones[i*10 +: 10] = 10'd1;
        rst_i = 1; in_valid_i = 0; in_sof_i = 0; in_data_i = '0; out_ready_i = 1;
        dp_force = 0; cur_syn = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        tick(1, 1, 1, rnd_beat(), 1, 0);          // strobes held low in reset
        tick(0, 0, 0, '0, 1, 0);

        // All-zero codeword, then one-error codeword (S_j = 1), back to back.
        cur_syn = '0;
        for (int b = 0; b < BEATS; b++) tick(0, 1, b == 0, '0, 1, 0);
        cur_syn = ones;
        for (int b = 0; b < BEATS; b++) tick(0, 1, b == 0, (b == BEATS - 1) ? DW'(1) : '0, 1, 0);
        tick(0, 0, 0, '0, 1, 0);

        // Consumer not ready during frame: only the last beat stalls.
        send_frame(rnd_syn(), 100, 0);
        cur_syn = rnd_syn();
        for (int b = 0; b < BEATS - 1; b++) tick(0, 1, b == 0, rnd_beat(), 0, 0);
        repeat (3) tick(0, 1, 0, rnd_beat(), 0, 0);
        tick(0, 1, 0, rnd_beat(), 1, 0);
        tick(0, 0, 0, '0, 1, 0);

        // Mid-frame sof at beat 9 restarts the frame.
        cur_syn = rnd_syn();
        for (int b = 0; b < 9; b++) tick(0, 1, b == 0, rnd_beat(), 1, 0);
        for (int b = 0; b < BEATS; b++) tick(0, 1, b == 0, rnd_beat(), 1, 0);
        tick(0, 0, 0, '0, 1, 0);

        // Beat without sof while idle is dropped.
        tick(0, 1, 0, rnd_beat(), 1, 0);
        tick(0, 0, 0, '0, 1, 0);

        // Unsolicited datapath result.
        cur_syn = rnd_syn();
        tick(0, 0, 0, '0, 1, 1);
        tick(0, 0, 0, '0, 1, 0);

        // Reset at beat 5, then a clean frame.
        for (int b = 0; b < 5; b++) tick(0, 1, b == 0, rnd_beat(), 1, 0);
        tick(1, 1, 0, rnd_beat(), 1, 0);
        tick(1, 0, 0, '0, 1, 0);
        send_frame(rnd_syn(), 100, 0);
        tick(0, 0, 0, '0, 1, 0);

        // Randomized frames with gaps and a sluggish consumer.
        for (int f = 0; f < 8; f++) send_frame((f == 3) ? '0 : rnd_syn(), 60, 30);
        repeat (4) tick(0, 0, 0, '0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
